// File: rtl/regfile_pkg.sv
// Shared types and helpers for the register-file write-back path.
package regfile_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 2 ** ADDR_W;

    // One pending register write: destination index plus value.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    // Row-enable decode: register 0 is hard-wired zero, so it never gets an enable.
    function automatic logic [NUM_REGS-1:0] onehot_dec(input logic [ADDR_W-1:0] a);
        logic [NUM_REGS-1:0] v;
        v = '0;
        if (a != '0) begin
            v[a] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// In-order FIFO of pending register writes.
// REGFILE_WB_FWD_EN: also exposes storage, head pointer and a per-slot valid
// mask so the controller can search pending writes for forwarding.
module wb_fifo
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  wb_entry_t       push_entry,
    input  logic            pop,
    output wb_entry_t       head_entry,
    output logic [CW-1:0]   count
`ifdef REGFILE_WB_FWD_EN
    ,
    output wb_entry_t [DEPTH-1:0] mem_q,
    output logic [DEPTH-1:0]      valid,
    output logic [PW-1:0]         head_q
`endif
);

    wb_entry_t [DEPTH-1:0] mem;
    logic [PW-1:0]         head;
    logic [PW-1:0]         tail;

    // Pointers wrap naturally because DEPTH is a power of two; occupancy tracks push/pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + PW'(1);
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; stale slots are never read while count excludes them.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= push_entry;
        end
    end

    assign head_entry = mem[head];

`ifdef REGFILE_WB_FWD_EN
    assign mem_q  = mem;
    assign head_q = head;

    // A slot is live when its age (distance from head) is below the occupancy.
    always_comb begin
        logic [PW-1:0] off;
        off   = '0;
        valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off      = PW'(i) - head;
            valid[i] = ({1'b0, off} < count);
        end
    end
`endif

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Write-back controller feeding the 32-entry register file: buffers write
// requests in order and retires at most one per cycle onto the shared D bus
// with a single row enable.
// REGFILE_WB_FWD_EN: adds fwd_addr/fwd_hit/fwd_data so read ports can see
// writes still queued or retired-but-not-yet-stored.
module regfile_wb_ctrl #(
    parameter int DATA_W = regfile_pkg::DATA_W,
    parameter int ADDR_W = regfile_pkg::ADDR_W,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ADDR_W-1:0]          in_addr,
    input  logic [DATA_W-1:0]          in_data,
    input  logic                       wr_stall,
    output logic [2**ADDR_W-1:0]       wr_en,
    output logic [DATA_W-1:0]          wr_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       idle
`ifdef REGFILE_WB_FWD_EN
    ,
    input  logic [ADDR_W-1:0]          fwd_addr,
    output logic                       fwd_hit,
    output logic [DATA_W-1:0]          fwd_data
`endif
);

    import regfile_pkg::*;

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_entry_t push_entry;
    wb_entry_t head_entry;
    logic      push;
    logic      pop;

    // in_ready comes from registered occupancy only, so a full FIFO refuses
    // even when it is draining this same edge.
    assign in_ready   = (count < CW'(DEPTH));
    assign push       = in_valid && in_ready;
    assign pop        = (count != '0) && !wr_stall;
    assign push_entry = '{addr: in_addr, data: in_data};
    assign idle       = (count == '0) && (wr_en == '0);

`ifdef REGFILE_WB_FWD_EN
    wb_entry_t [DEPTH-1:0] fifo_mem;
    logic [DEPTH-1:0]      fifo_valid;
    logic [PW-1:0]         fifo_head;
    logic [ADDR_W-1:0]     wr_addr_q;
    logic [PW-1:0]         idx;
`endif

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head_entry (head_entry),
        .count      (count)
`ifdef REGFILE_WB_FWD_EN
        ,
        .mem_q      (fifo_mem),
        .valid      (fifo_valid),
        .head_q     (fifo_head)
`endif
    );

    // Retire the head into the output registers; enables drop when nothing retires but data holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en   <= '0;
            wr_data <= '0;
        end else if (pop) begin
            wr_en   <= onehot_dec(head_entry.addr);
            wr_data <= head_entry.data;
        end else begin
            wr_en   <= '0;
        end
    end

`ifdef REGFILE_WB_FWD_EN
    // Remember which register the in-flight write targets for forwarding.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_addr_q <= '0;
        end else if (pop) begin
            wr_addr_q <= head_entry.addr;
        end
    end

    // Search oldest to youngest (in-flight first, then FIFO by age) so the last match wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = '0;
        if (fwd_addr != '0) begin
            if ((wr_en != '0) && (wr_addr_q == fwd_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = wr_data;
            end
            for (int k = 0; k < DEPTH; k++) begin
                idx = fifo_head + PW'(k);
                if (fifo_valid[idx] && (fifo_mem[idx].addr == fwd_addr)) begin
                    fwd_hit  = 1'b1;
                    fwd_data = fifo_mem[idx].data;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Self-checking bench for regfile_wb_ctrl: queue-based reference model plus a
// behavioural register file fed from the DUT's wr_en/wr_data.
module tb_regfile_wb_ctrl;

    import regfile_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_addr;
    logic [31:0] in_data;
    logic        wr_stall;
    logic [31:0] wr_en;
    logic [31:0] wr_data;
    logic [2:0]  count;
    logic        idle;
`ifdef REGFILE_WB_FWD_EN
    logic [4:0]  fwd_addr;
    logic        fwd_hit;
    logic [31:0] fwd_data;
`endif

    // Reference model state.
    wb_entry_t   q[$];
    logic [31:0] exp_wr_en;
    logic [31:0] exp_wr_data;
    logic [4:0]  exp_wr_addr;
    logic [31:0] model_rf [32];
    logic [31:0] dut_rf   [32];

    int n_checks = 0;
    int n_pass   = 0;

    regfile_wb_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_addr  (in_addr),
        .in_data  (in_data),
        .wr_stall (wr_stall),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .count    (count),
        .idle     (idle)
`ifdef REGFILE_WB_FWD_EN
        ,
        .fwd_addr (fwd_addr),
        .fwd_hit  (fwd_hit),
        .fwd_data (fwd_data)
`endif
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        q.delete();
        exp_wr_en   = '0;
        exp_wr_data = '0;
        exp_wr_addr = '0;
    endtask

    // One clock: drive inputs at the negedge, advance model and register files
    // across the posedge, return at the next negedge.
    task automatic cycle(input logic v, input logic [4:0] a, input logic [31:0] d,
                         input logic s, output logic acc);
        logic [31:0] cap_en;
        logic [31:0] cap_d;
        logic        do_pop;
        wb_entry_t   e;
        in_valid = v;
        in_addr  = a;
        in_data  = d;
        wr_stall = s;
        acc      = v && (q.size() < 4);
        do_pop   = (q.size() != 0) && !s;
        cap_en   = wr_en;
        cap_d    = wr_data;
        @(posedge clk);
        for (int i = 0; i < 32; i++) begin
            if (cap_en[i]) dut_rf[i] = cap_d;
        end
        if (exp_wr_en != '0) model_rf[exp_wr_addr] = exp_wr_data;
        if (do_pop) begin
            e           = q.pop_front();
            exp_wr_addr = e.addr;
            exp_wr_data = e.data;
            exp_wr_en   = (e.addr == 5'd0) ? 32'd0 : (32'd1 << e.addr);
        end else begin
            exp_wr_en = '0;
        end
        if (acc) q.push_back('{addr: a, data: d});
        @(negedge clk);
    endtask

    task automatic model_fwd(input logic [4:0] a, output logic hit, output logic [31:0] data);
        hit  = 1'b0;
        data = '0;
        if (a != 5'd0) begin
            if (exp_wr_en != '0 && exp_wr_addr == a) begin
                hit  = 1'b1;
                data = exp_wr_data;
            end
            foreach (q[i]) begin
                if (q[i].addr == a) begin
                    hit  = 1'b1;
                    data = q[i].data;
                end
            end
        end
    endtask

    task automatic test_reset();
        logic acc;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_addr  = '0;
        in_data  = '0;
        wr_stall = 1'b0;
        for (int i = 0; i < 32; i++) begin
            model_rf[i] = '0;
            dut_rf[i]   = '0;
        end
        model_reset();
        repeat (2) @(negedge clk);
        n_checks++; if (wr_en !== 32'd0) $display("[TB] FAIL reset_wr_en: got %h expected 0", wr_en); else n_pass++;
        n_checks++; if (wr_data !== 32'd0) $display("[TB] FAIL reset_wr_data: got %h expected 0", wr_data); else n_pass++;
        n_checks++; if (count !== 3'd0) $display("[TB] FAIL reset_count: got %0d expected 0", count); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); else n_pass++;
        n_checks++; if (idle !== 1'b1) $display("[TB] FAIL reset_idle: got %b expected 1", idle); else n_pass++;
        rst = 1'b0;
        // Traffic, then a reset pulse in the middle of a cycle.
        cycle(1'b1, 5'd9, 32'h1111_2222, 1'b0, acc);
        cycle(1'b1, 5'd10, 32'h3333_4444, 1'b0, acc);
        cycle(1'b1, 5'd11, 32'h5555_6666, 1'b1, acc);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_checks++; if (wr_en !== 32'd0) $display("[TB] FAIL pulse_wr_en: got %h expected 0", wr_en); else n_pass++;
        n_checks++; if (wr_data !== 32'd0) $display("[TB] FAIL pulse_wr_data: got %h expected 0", wr_data); else n_pass++;
        n_checks++; if (count !== 3'd0) $display("[TB] FAIL pulse_count: got %0d expected 0", count); else n_pass++;
        n_checks++; if (idle !== 1'b1 || in_ready !== 1'b1) $display("[TB] FAIL pulse_idle_ready: got %b%b expected 11", idle, in_ready); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_single_write();
        logic acc;
        cycle(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, acc);
        n_checks++; if (count !== 3'd1 || wr_en !== 32'd0) $display("[TB] FAIL single_e0: got count %0d wr_en %h expected 1 / 0", count, wr_en); else n_pass++;
        cycle(1'b0, 5'd0, 32'd0, 1'b0, acc);
        n_checks++; if (wr_en !== 32'h0000_0020) $display("[TB] FAIL single_wr_en: got %h expected 00000020", wr_en); else n_pass++;
        n_checks++; if (wr_data !== 32'hDEAD_BEEF) $display("[TB] FAIL single_wr_data: got %h expected deadbeef", wr_data); else n_pass++;
        cycle(1'b0, 5'd0, 32'd0, 1'b0, acc);
        n_checks++; if (dut_rf[5] !== 32'hDEAD_BEEF) $display("[TB] FAIL single_row5: got %h expected deadbeef", dut_rf[5]); else n_pass++;
        n_checks++; if (idle !== 1'b1 || wr_en !== 32'd0) $display("[TB] FAIL single_idle: got idle %b wr_en %h expected 1 / 0", idle, wr_en); else n_pass++;
    endtask

    task automatic test_fill_backpressure();
        wb_entry_t reqs [5];
        logic      acc;
        logic      held;
        int        n_acc;
        n_acc = 0;
        for (int k = 0; k < 5; k++) begin
            reqs[k].addr = 5'($urandom_range(1, 31));
            reqs[k].data = $urandom;
        end
        for (int k = 0; k < 5; k++) begin
            cycle(1'b1, reqs[k].addr, reqs[k].data, 1'b1, acc);
            if (acc) n_acc++;
            n_checks++; if (wr_en !== 32'd0) $display("[TB] FAIL fill_stalled_wr_en %0d: got %h expected 0", k, wr_en); else n_pass++;
        end
        n_checks++; if (n_acc != 4 || count !== 3'd4) $display("[TB] FAIL fill_count: got %0d (model accepted %0d) expected 4", count, n_acc); else n_pass++;
        n_checks++; if (in_ready !== 1'b0) $display("[TB] FAIL fill_in_ready: got %b expected 0", in_ready); else n_pass++;
        // Release the stall while holding the refused fifth request stable.
        held = 1'b1;
        for (int c = 0; c < 5; c++) begin
            cycle(held, reqs[4].addr, reqs[4].data, 1'b0, acc);
            if (acc) held = 1'b0;
            n_checks++;
            if (wr_en !== (32'd1 << reqs[c].addr) || wr_data !== reqs[c].data)
                $display("[TB] FAIL drain_order %0d: got %h/%h expected %h/%h", c, wr_en, wr_data, 32'd1 << reqs[c].addr, reqs[c].data);
            else n_pass++;
        end
        n_checks++; if (held !== 1'b0) $display("[TB] FAIL held_request_accepted: got held %b expected 0", held); else n_pass++;
        cycle(1'b0, 5'd0, 32'd0, 1'b0, acc);
    endtask

    task automatic test_reg_zero();
        logic acc;
        cycle(1'b1, 5'd0, 32'h1234_5678, 1'b0, acc);
        cycle(1'b1, 5'd3, 32'h1, 1'b0, acc);
        n_checks++; if (wr_en !== 32'd0 || wr_data !== 32'h1234_5678) $display("[TB] FAIL reg0_wr_en: got %h/%h expected 0/12345678", wr_en, wr_data); else n_pass++;
        cycle(1'b1, 5'd3, 32'h2, 1'b0, acc);
        for (int c = 0; c < 3; c++) begin
            cycle(1'b0, 5'd0, 32'd0, 1'b0, acc);
            n_checks++; if (wr_en !== exp_wr_en) $display("[TB] FAIL reg0_drain %0d: got %h expected %h", c, wr_en, exp_wr_en); else n_pass++;
        end
        n_checks++; if (dut_rf[0] !== 32'd0) $display("[TB] FAIL reg0_row0: got %h expected 0", dut_rf[0]); else n_pass++;
        n_checks++; if (dut_rf[3] !== 32'h2) $display("[TB] FAIL reg0_row3_last_wins: got %h expected 2", dut_rf[3]); else n_pass++;
    endtask

    task automatic test_random();
        logic        acc;
        logic        v;
        logic        s;
        logic [4:0]  a;
        logic [31:0] d;
        logic        pend;
        int          errs;
`ifdef REGFILE_WB_FWD_EN
        logic        m_hit;
        logic [31:0] m_data;
`endif
        pend = 1'b0;
        a    = '0;
        d    = '0;
        errs = 0;
        for (int c = 0; c < 400; c++) begin
            s = ($urandom_range(0, 3) == 0);
            if (pend) begin
                v = 1'b1;
            end else begin
                v = ($urandom_range(0, 3) != 0);
                a = 5'($urandom);
                d = $urandom;
            end
            cycle(v, a, d, s, acc);
            pend = v && !acc;
            n_checks++; if (wr_en !== exp_wr_en) $display("[TB] FAIL rand_wr_en %0d: got %h expected %h", c, wr_en, exp_wr_en); else n_pass++;
            n_checks++; if (wr_data !== exp_wr_data) $display("[TB] FAIL rand_wr_data %0d: got %h expected %h", c, wr_data, exp_wr_data); else n_pass++;
            n_checks++; if (count !== 3'(q.size())) $display("[TB] FAIL rand_count %0d: got %0d expected %0d", c, count, q.size()); else n_pass++;
            n_checks++; if (in_ready !== (q.size() < 4)) $display("[TB] FAIL rand_in_ready %0d: got %b expected %b", c, in_ready, q.size() < 4); else n_pass++;
            n_checks++; if (idle !== (q.size() == 0 && exp_wr_en == 0)) $display("[TB] FAIL rand_idle %0d: got %b", c, idle); else n_pass++;
`ifdef REGFILE_WB_FWD_EN
            fwd_addr = ($urandom_range(0, 1) == 0 && q.size() != 0) ? q[$urandom_range(0, q.size() - 1)].addr : 5'($urandom);
            #1;
            model_fwd(fwd_addr, m_hit, m_data);
            n_checks++;
            if (fwd_hit !== m_hit || fwd_data !== m_data)
                $display("[TB] FAIL rand_fwd %0d: got %b/%h expected %b/%h", c, fwd_hit, fwd_data, m_hit, m_data);
            else n_pass++;
`endif
        end
        for (int c = 0; c < 8; c++) begin
            cycle(1'b0, 5'd0, 32'd0, 1'b0, acc);
        end
        for (int i = 0; i < 32; i++) begin
            if (dut_rf[i] !== model_rf[i]) begin
                errs++;
                $display("[TB] FAIL rand_row %0d: got %h expected %h", i, dut_rf[i], model_rf[i]);
            end
        end
        n_checks++; if (errs == 0) n_pass++;
    endtask

    task automatic test_reset_mid_drain();
        logic acc;
        cycle(1'b1, 5'd12, 32'hAAAA_0001, 1'b1, acc);
        cycle(1'b1, 5'd13, 32'hAAAA_0002, 1'b1, acc);
        cycle(1'b1, 5'd14, 32'hAAAA_0003, 1'b1, acc);
        in_valid = 1'b0;
        n_checks++; if (count !== 3'd3) $display("[TB] FAIL middrain_pending: got %0d expected 3", count); else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_checks++; if (count !== 3'd0) $display("[TB] FAIL middrain_count: got %0d expected 0", count); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int c = 0; c < 5; c++) begin
            cycle(1'b0, 5'd0, 32'd0, 1'b0, acc);
            n_checks++; if (wr_en !== 32'd0 || idle !== 1'b1) $display("[TB] FAIL middrain_no_pulse %0d: got %h idle %b expected 0 / 1", c, wr_en, idle); else n_pass++;
        end
    endtask

`ifdef REGFILE_WB_FWD_EN
    task automatic test_forwarding();
        logic acc;
        cycle(1'b1, 5'd7, 32'hA, 1'b1, acc);
        cycle(1'b1, 5'd7, 32'hB, 1'b1, acc);
        fwd_addr = 5'd7;
        #1;
        n_checks++; if (fwd_hit !== 1'b1 || fwd_data !== 32'hB) $display("[TB] FAIL fwd_youngest: got %b/%h expected 1/b", fwd_hit, fwd_data); else n_pass++;
        fwd_addr = 5'd0;
        #1;
        n_checks++; if (fwd_hit !== 1'b0 || fwd_data !== 32'd0) $display("[TB] FAIL fwd_addr0: got %b/%h expected 0/0", fwd_hit, fwd_data); else n_pass++;
        fwd_addr = 5'd7;
        cycle(1'b0, 5'd0, 32'd0, 1'b0, acc);
        cycle(1'b0, 5'd0, 32'd0, 1'b0, acc);
        #1;
        n_checks++; if (fwd_hit !== 1'b1 || fwd_data !== 32'hB) $display("[TB] FAIL fwd_inflight: got %b/%h expected 1/b", fwd_hit, fwd_data); else n_pass++;
        cycle(1'b0, 5'd0, 32'd0, 1'b0, acc);
        #1;
        n_checks++; if (fwd_hit !== 1'b0 || fwd_data !== 32'd0) $display("[TB] FAIL fwd_retired: got %b/%h expected 0/0", fwd_hit, fwd_data); else n_pass++;
    endtask
`endif

    initial begin
`ifdef REGFILE_WB_FWD_EN
        fwd_addr = '0;
`endif
        test_reset();
        test_single_write();
        test_fill_backpressure();
        test_reg_zero();
        test_reset_mid_drain();
`ifdef REGFILE_WB_FWD_EN
        test_forwarding();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
